// File: rtl/issue_sched.sv
// Issue scheduler: grants int/ld/mult/div issue against a reservation map of
// future CDB write slots so no two results reach the CDB in the same cycle.
module issue_sched #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic       ld_req,
  input  logic       mult_req,
  input  logic       div_req,
  input  logic       flush,
  output logic       int_grant,
  output logic       ld_grant,
  output logic       mult_grant,
  output logic       div_grant,
  output logic       cdb_valid,
  output logic [1:0] cdb_src,
  output logic       div_busy
);

  localparam int unsigned SRC_W = 2;
  localparam int unsigned CNT_W = 3;

  localparam logic [SRC_W-1:0] SRC_INT  = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_LD   = SRC_W'(1);
  localparam logic [SRC_W-1:0] SRC_MULT = SRC_W'(2);
  localparam logic [SRC_W-1:0] SRC_DIV  = SRC_W'(3);

  // resv[k]: CDB slot k cycles ahead is taken; own[k] names its writer
  logic [DIV_LAT:1]            resv;
  logic [DIV_LAT:1][SRC_W-1:0] own;
  logic [CNT_W-1:0]            div_cnt;
  logic                        rr;

  logic [DIV_LAT:1]            resv_nxt;
  logic [DIV_LAT:1][SRC_W-1:0] own_nxt;
  logic [CNT_W-1:0]            div_cnt_nxt;

  // Same-cycle grants; int/ld share slot 1 and arbitrate round-robin
  always_comb begin
    int_grant  = 1'b0;
    ld_grant   = 1'b0;
    mult_grant = 1'b0;
    div_grant  = 1'b0;
    if (!flush && !reset) begin
      div_grant  = div_req & ~resv[DIV_LAT] & (div_cnt == '0);
      mult_grant = mult_req & ~resv[MULT_LAT];
      if (!resv[1]) begin
        if (int_req && ld_req) begin
          int_grant = ~rr;
          ld_grant  = rr;
        end else begin
          int_grant = int_req;
          ld_grant  = ld_req;
        end
      end
    end
  end

  // Shift the map one slot closer and insert the long-latency claims
  always_comb begin
    resv_nxt = '0;
    own_nxt  = '0;
    for (int k = 1; k < DIV_LAT; k++) begin
      resv_nxt[k] = resv[k+1];
      own_nxt[k]  = own[k+1];
    end
    if (mult_grant) begin
      resv_nxt[MULT_LAT-1] = 1'b1;
      own_nxt[MULT_LAT-1]  = SRC_MULT;
    end
    if (div_grant) begin
      resv_nxt[DIV_LAT-1] = 1'b1;
      own_nxt[DIV_LAT-1]  = SRC_DIV;
    end
    if (div_grant) begin
      div_cnt_nxt = CNT_W'(DIV_LAT - 1);
    end else if (div_cnt != '0) begin
      div_cnt_nxt = div_cnt - CNT_W'(1);
    end else begin
      div_cnt_nxt = div_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resv      <= '0;
      own       <= '0;
      div_cnt   <= '0;
      rr        <= 1'b0;
      cdb_valid <= 1'b0;
      cdb_src   <= SRC_INT;
      div_busy  <= 1'b0;
    end else if (flush) begin
      // Mispredict kills every in-flight result; arbitration fairness is kept
      resv      <= '0;
      own       <= '0;
      div_cnt   <= '0;
      cdb_valid <= 1'b0;
      cdb_src   <= SRC_INT;
      div_busy  <= 1'b0;
    end else begin
      resv      <= resv_nxt;
      own       <= own_nxt;
      div_cnt   <= div_cnt_nxt;
      div_busy  <= (div_cnt_nxt != '0);
      cdb_valid <= resv[1] | int_grant | ld_grant;
      if (resv[1]) begin
        cdb_src <= own[1];
      end else if (int_grant) begin
        cdb_src <= SRC_INT;
      end else if (ld_grant) begin
        cdb_src <= SRC_LD;
      end
      if (int_grant) begin
        rr <= 1'b1;
      end else if (ld_grant) begin
        rr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: scripted grant expectations feed a
// scoreboard of expected CDB writes; a monitor aborts on slot collisions.
module tb_issue_sched;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 6;

  logic       clk;
  logic       reset;
  logic       int_req, ld_req, mult_req, div_req, flush;
  logic       int_grant, ld_grant, mult_grant, div_grant;
  logic       cdb_valid;
  logic [1:0] cdb_src;
  logic       div_busy;

  typedef struct {
    int         due;
    logic [1:0] src;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int        mon_q[$];
  int        cyc;
  int        n_cmp;
  int        n_err;

  issue_sched #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .int_req    (int_req),
    .ld_req     (ld_req),
    .mult_req   (mult_req),
    .div_req    (div_req),
    .flush      (flush),
    .int_grant  (int_grant),
    .ld_grant   (ld_grant),
    .mult_grant (mult_grant),
    .div_grant  (div_grant),
    .cdb_valid  (cdb_valid),
    .cdb_src    (cdb_src),
    .div_busy   (div_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic sb_push(input int due, input logic [1:0] src);
    sb_entry_t e;
    e.due = due;
    e.src = src;
    sb_q.push_back(e);
  endtask

  // Independent watch on the DUT's own grants: two writers in one slot is fatal
  task automatic claim(input int due, input string who);
    foreach (mon_q[n]) begin
      if (mon_q[n] == due) begin
        $display("FAIL cdb_collision %s @cyc %0d: got second writer for slot %0d expected none", who, cyc, due);
        $fatal(1, "cdb slot collision");
      end
    end
    mon_q.push_back(due);
  endtask

  // One cycle: check registered outputs, drive inputs, check grants, advance
  task automatic step(input logic i, input logic l, input logic m, input logic d,
                      input logic f, input logic [3:0] eg, input logic eb);
    logic       found;
    logic [1:0] src;
    found = 1'b0;
    src   = 2'd0;
    for (int n = sb_q.size() - 1; n >= 0; n--) begin
      if (sb_q[n].due == cyc) begin
        found = 1'b1;
        src   = sb_q[n].src;
        sb_q.delete(n);
      end
    end
    check("cdb_valid", 8'(cdb_valid), 8'(found));
    if (found) check("cdb_src", 8'(cdb_src), 8'(src));
    check("div_busy", 8'(div_busy), 8'(eb));

    int_req  = i;
    ld_req   = l;
    mult_req = m;
    div_req  = d;
    flush    = f;
    #1;
    check("grants{i,l,m,d}", 8'({int_grant, ld_grant, mult_grant, div_grant}), 8'(eg));

    for (int n = mon_q.size() - 1; n >= 0; n--) begin
      if (mon_q[n] <= cyc) mon_q.delete(n);
    end
    if (int_grant)  claim(cyc + 1, "int");
    if (ld_grant)   claim(cyc + 1, "ld");
    if (mult_grant) claim(cyc + int'(MULT_LAT), "mult");
    if (div_grant)  claim(cyc + int'(DIV_LAT), "div");

    if (f) begin
      sb_q.delete();
      mon_q.delete();
    end else begin
      if (eg[3]) sb_push(cyc + 1, 2'd0);
      if (eg[2]) sb_push(cyc + 1, 2'd1);
      if (eg[1]) sb_push(cyc + int'(MULT_LAT), 2'd2);
      if (eg[0]) sb_push(cyc + int'(DIV_LAT), 2'd3);
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input logic eb);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, eb);
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    cyc      = 0;
    reset    = 1'b1;
    int_req  = 1'b1;
    ld_req   = 1'b0;
    mult_req = 1'b1;
    div_req  = 1'b1;
    flush    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_grants", 8'({int_grant, ld_grant, mult_grant, div_grant}), 8'h0);
    check("rst_regs", 8'({cdb_valid, cdb_src, div_busy}), 8'h0);
    int_req  = 1'b0;
    mult_req = 1'b0;
    div_req  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single int issue, latency 1
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    idle(1, 1'b0);

    // Lone ld issue, leaves int preferred for the alternation test
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (k % 2 == 0) ? 4'b1000 : 4'b0100, 1'b0);
    idle(2, 1'b0);

    // Div then mult: mult blocked where its slot equals the div slot
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    idle(2, 1'b1);
    idle(3, 1'b0);

    // Back-to-back divides: one every DIV_LAT cycles
    for (int k = 0; k <= 12; k++)
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, (k % 6 == 0) ? 4'b0001 : 4'b0000,
           (k % 6 != 0) ? 1'b1 : 1'b0);
    for (int k = 13; k <= 18; k++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, (k < 18) ? 1'b1 : 1'b0);

    // Mult reservation blocks int in the cycle before it lands
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    idle(2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    idle(2, 1'b0);

    // Flush kills the pending div; grants masked while flushing
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0);
    idle(5, 1'b1);
    idle(2, 1'b0);

    // Reset mid-operation: immediate, all outputs low, rr back to int
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b0);
    reset    = 1'b1;
    int_req  = 1'b1;
    ld_req   = 1'b1;
    mult_req = 1'b1;
    div_req  = 1'b1;
    #1;
    check("rst_async", 8'({int_grant, ld_grant, mult_grant, div_grant, cdb_valid, div_busy}), 8'h0);
    check("rst_async_src", 8'(cdb_src), 8'h0);
    sb_q.delete();
    mon_q.delete();
    @(posedge clk);
    #1;
    cyc++;
    check("rst_hold", 8'({int_grant, ld_grant, mult_grant, div_grant, cdb_valid, div_busy}), 8'h0);
    reset    = 1'b0;
    int_req  = 1'b0;
    ld_req   = 1'b0;
    mult_req = 1'b0;
    div_req  = 1'b0;
    cyc++;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    idle(2, 1'b0);

    check("sb_drained", 8'(sb_q.size()), 8'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
